serial_word_rx: RTL and testbench
=================================

Name: serial_word_rx

Overview:
Serial-to-parallel frame receiver: the receiving end of a serial link driven by a shift-register serializer (one bit per strobe, LSB-first or MSB-first).
- Detects a start bit, shifts in WIDTH data bits, checks the stop bit, then presents the assembled word on a valid/ready parallel interface.
- Sits between a serial line (pin or on-chip serializer output) and a parallel consumer. Flags overrun and framing errors.

Parameters:
- WIDTH, 4, data bits per frame (>=2).
- MSB_FIRST, 0, 0 = first data bit lands in D_par[0] (right-shift serializer); 1 = first data bit lands in D_par[WIDTH-1] (left-shift serializer).

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- ser_i  input  1  serial line; idles high.
- bit_en_i  input  1  bit strobe; ser_i is sampled only on cycles with bit_en_i=1.
- D_par  output  WIDTH  received word; stable while valid_o=1.
- valid_o  output  1  D_par holds an unconsumed word.
- ready_i  input  1  consumer accepts D_par when valid_o & ready_i.
- busy_o  output  1  frame reception in progress (state != IDLE).
- overrun_o  output  1  sticky: a completed frame was dropped.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled 0.
- clr_err_i  input  1  clears overrun_o (and parity_err_o when present).

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state=IDLE, shift reg=0, D_par=0, valid_o=0, overrun_o=0, frame_err_o=0. Reset overrides every other input, including mid-frame; a partial frame is discarded.
- Strobe cycles: all FSM transitions occur only on cycles with bit_en_i=1, except the handshake and clr_err_i, which act every cycle.
- FSM states:
  - IDLE: ser_i=0 on strobe -> DATA, bit counter=0.
  - DATA: shift ser_i into the shift reg (MSB_FIRST=0: {ser_i, sr[WIDTH-1:1]}; MSB_FIRST=1: {sr[WIDTH-2:0], ser_i}); counter++. After the WIDTH-th data bit -> STOP (or PAR when compiled in).
  - STOP: ser_i=1 -> word complete, go to IDLE. ser_i=0 -> frame_err_o pulses 1 cycle, word discarded, go to BREAK.
  - BREAK: wait for ser_i=1 on a strobe, then -> IDLE. This prevents a held-low line from retriggering a frame.
- Output buffer:
  - On word complete: if the buffer is free (valid_o=0, or valid_o & ready_i in the same cycle), D_par<=word and valid_o<=1 on the next edge.
  - Latency: valid_o rises on the edge after the stop-bit strobe cycle.
  - If the buffer is occupied and not consumed: the new word is dropped, D_par unchanged, overrun_o<=1.
- Handshake:
  - valid_o & ready_i with no completion -> valid_o<=0; D_par holds its last value.
  - ready_i while valid_o=0 is ignored.
- clr_err_i:
  - Clears overrun_o on the next edge.
  - If clr_err_i coincides with a new overrun event, the set wins.
- busy_o = (state != IDLE); combinational from state.
- Strobe gaps: bit_en_i low for any number of cycles freezes the FSM (no timeout).

Optional Feature:
- Macro SERIAL_WORD_RX_PARITY_EN.
- Defined:
  - Adds state PAR between DATA and STOP; it samples one even-parity bit (XOR of data bits and parity bit must be 0).
  - Adds output port parity_err_o (1 bit, sticky, reset 0, cleared by clr_err_i).
  - On mismatch: parity_err_o<=1, but the word is still delivered if the stop bit is good.
- Not defined: no PAR state, no parity_err_o port; frame is start + WIDTH data + stop.

Test Plan:
- Basic LSB-first (WIDTH=4, MSB_FIRST=0, bit_en_i=1 every cycle): ser_i = 0,1,0,1,1,1 -> D_par=4'b1101, valid_o=1 one edge after the stop bit; ready_i=1 -> valid_o=0 next edge.
- MSB-first (MSB_FIRST=1): same bit sequence -> D_par=4'b1011; strobe every 3rd cycle -> identical result, valid_o timing tied to the stop-bit strobe.
- Overrun: two back-to-back frames 4'b0011 then 4'b1100 with ready_i=0 -> D_par=4'b0011, overrun_o=1. Then clr_err_i=1 -> overrun_o=0. Repeat with ready_i=1 on the completion cycle -> D_par=4'b1100, overrun_o=0.
- Framing error: frame with stop bit 0, ser_i held 0 for 5 strobes, then 1 -> frame_err_o pulses once, valid_o stays 0, busy_o=1 until ser_i returns high, no spurious second frame.
- Reset mid-frame: rst_i=1 after 2 data bits -> busy_o=0, D_par=0, valid_o=0. A following clean frame 4'b0110 is received correctly.
- Parity (macro defined): data 4'b0111 with parity bit 1 -> parity_err_o=0. Same data with parity bit 0 -> parity_err_o=1, D_par=4'b0111 still delivered.

Source files
------------

// File: rtl/serial_word_rx.sv
// Start/data/stop serial frame receiver with a one-word valid/ready output buffer; word valid one edge after the stop strobe,
// a completed word is dropped (overrun_o) when the buffer is held. Define SERIAL_WORD_RX_PARITY_EN for an even-parity bit.
module serial_word_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ser_i,
  input  logic             bit_en_i,
  output logic [WIDTH-1:0] D_par,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             frame_err_o,
`ifdef SERIAL_WORD_RX_PARITY_EN
  output logic             parity_err_o,
`endif
  input  logic             clr_err_i
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_WORD_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, DATA, STOP, BRK} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    cnt;
  logic             complete;
  logic             bad_stop;

  always_comb begin
    sr_nxt   = MSB_FIRST ? {sr[WIDTH-2:0], ser_i} : {ser_i, sr[WIDTH-1:1]};
    complete = (state == STOP) && bit_en_i && ser_i;
    bad_stop = (state == STOP) && bit_en_i && !ser_i;
    busy_o   = (state != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      D_par        <= '0;
      valid_o      <= 1'b0;
      overrun_o    <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= bad_stop;

      // Clears are written first so a same-cycle set below takes priority.
      if (clr_err_i) begin
        overrun_o    <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
        parity_err_o <= 1'b0;
`endif
      end

      if (bit_en_i) begin
        case (state)
          IDLE: begin
            if (!ser_i) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            sr  <= sr_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
              state <= PAR;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SERIAL_WORD_RX_PARITY_EN
          PAR: begin
            if ((^sr) ^ ser_i) parity_err_o <= 1'b1;
            state <= STOP;
          end
`endif
          STOP:    state <= ser_i ? IDLE : BRK;
          // A line held low after a bad stop bit must not look like a new start bit.
          BRK:     if (ser_i) state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (complete) begin
        if (!valid_o || ready_i) begin
          D_par   <= sr;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: an LSB-first and an MSB-first instance share one serial line; accepted words are scoreboarded.
module tb_serial_word_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ser, bit_en, ready, clr;
  logic [3:0] d0, d1;
  logic       v0, v1, b0, b1, o0, o1, f0, f1;
`ifdef SERIAL_WORD_RX_PARITY_EN
  logic       pe0, pe1;
`endif

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .ser_i(ser), .bit_en_i(bit_en),
    .D_par(d0), .valid_o(v0), .ready_i(ready), .busy_o(b0),
    .overrun_o(o0), .frame_err_o(f0),
`ifdef SERIAL_WORD_RX_PARITY_EN
    .parity_err_o(pe0),
`endif
    .clr_err_i(clr)
  );

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .ser_i(ser), .bit_en_i(bit_en),
    .D_par(d1), .valid_o(v1), .ready_i(ready), .busy_o(b1),
    .overrun_o(o1), .frame_err_o(f1),
`ifdef SERIAL_WORD_RX_PARITY_EN
    .parity_err_o(pe1),
`endif
    .clr_err_i(clr)
  );

  typedef struct {
    logic [3:0] w0;
    logic [3:0] w1;
  } exp_t;

  typedef struct {
    logic [3:0] data;
    logic       stop;
    int         gap;
  } vec_t;

  exp_t q[$];
  vec_t tbl[7];
  int   total = 0;
  int   bad = 0;
  int   ferr_cnt = 0;

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    ser    = b;
    bit_en = 1'b1;
    step();
    bit_en = 1'b0;
    repeat (gap - 1) step();
  endtask

  // Start bit, data LSB first on the wire, parity bit when compiled in (flip makes it wrong).
  task automatic send_data(input logic [3:0] data, input int gap, input logic flip);
    send_bit(1'b0, gap);
    for (int i = 0; i < 4; i++) send_bit(data[i], gap);
`ifdef SERIAL_WORD_RX_PARITY_EN
    send_bit((^data) ^ flip, gap);
`else
    if (flip) $display("note: parity flip ignored without parity build");
`endif
  endtask

  task automatic push_exp(input logic [3:0] data);
    exp_t e;
    e.w0 = data;
    e.w1 = rev4(data);
    q.push_back(e);
  endtask

  // Monitor: every negedge with valid & ready is an acceptance on the following edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (f0) ferr_cnt++;
      if (v0 && ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got word %0h expected none", d0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_lsb_word", 32'(d0), 32'(e.w0));
          chk("sb_msb_word", 32'(d1), 32'(e.w1));
        end
      end
    end
  end

  initial begin
    int fc;
    tbl[0] = '{4'b1101, 1'b1, 1};
    tbl[1] = '{4'b1101, 1'b1, 3};
    tbl[2] = '{4'b0000, 1'b1, 1};
    tbl[3] = '{4'b1111, 1'b1, 2};
    tbl[4] = '{4'b1010, 1'b0, 1};
    tbl[5] = '{4'b0110, 1'b1, 3};
    tbl[6] = '{4'b1001, 1'b0, 2};

    rst = 1'b1; ser = 1'b1; bit_en = 1'b0; ready = 1'b0; clr = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(v0), 0);
    chk("rst_dpar", 32'(d0), 0);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_overrun", 32'(o0), 0);
    chk("rst_frame_err", 32'(f0), 0);
    rst = 1'b0;
    step();

    // Basic frame with explicit valid timing around the stop strobe.
    send_data(4'b1101, 1, 1'b0);
    chk("basic_pre_valid", 32'(v0), 0);
    chk("basic_pre_busy", 32'(b0), 1);
    push_exp(4'b1101);
    send_bit(1'b1, 1);
    chk("basic_valid", 32'(v0), 1);
    chk("basic_lsb", 32'(d0), 32'(4'b1101));
    chk("basic_msb", 32'(d1), 32'(4'b1011));
    chk("basic_busy", 32'(b0), 0);
    ready = 1'b1;
    step();
    chk("basic_consumed", 32'(v0), 0);
    chk("basic_hold", 32'(d0), 32'(4'b1101));

    for (int i = 0; i < 7; i++) begin
      fc = ferr_cnt;
      send_data(tbl[i].data, tbl[i].gap, 1'b0);
      if (tbl[i].stop) push_exp(tbl[i].data);
      send_bit(tbl[i].stop, tbl[i].gap);
      send_bit(1'b1, tbl[i].gap);
      step();
      chk("tbl_ferr", 32'(ferr_cnt - fc), tbl[i].stop ? 0 : 1);
      chk("tbl_busy", 32'(b0), 0);
      chk("tbl_overrun", 32'(o0), 0);
      chk("tbl_valid", 32'(v0), 0);
    end

    // Overrun: second word dropped while the first is held.
    ready = 1'b0;
    send_data(4'b0011, 1, 1'b0); push_exp(4'b0011); send_bit(1'b1, 1);
    send_data(4'b1100, 1, 1'b0); send_bit(1'b1, 1);
    chk("ovr_dpar", 32'(d0), 32'(4'b0011));
    chk("ovr_flag", 32'(o0), 1);
    chk("ovr_valid", 32'(v0), 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ovr_cleared", 32'(o0), 0);
    ready = 1'b1; step(); ready = 1'b0; step();

    // Consumer ready exactly on the completion edge: no overrun.
    send_data(4'b0011, 1, 1'b0); push_exp(4'b0011); send_bit(1'b1, 1);
    send_data(4'b1100, 1, 1'b0); push_exp(4'b1100);
    ready = 1'b1;
    send_bit(1'b1, 1);
    chk("swap_dpar", 32'(d0), 32'(4'b1100));
    chk("swap_overrun", 32'(o0), 0);
    step();
    chk("swap_drained", 32'(v0), 0);

    // Set beats clear when both land on one edge.
    ready = 1'b0;
    send_data(4'b0101, 1, 1'b0); push_exp(4'b0101); send_bit(1'b1, 1);
    send_data(4'b1010, 1, 1'b0);
    clr = 1'b1;
    send_bit(1'b1, 1);
    clr = 1'b0;
    chk("set_wins", 32'(o0), 1);
    clr = 1'b1; step(); clr = 1'b0;
    ready = 1'b1; step(); step();

    // Framing error with the line held low afterwards.
    fc = ferr_cnt;
    send_data(4'b1001, 1, 1'b0);
    send_bit(1'b0, 1);
    repeat (5) send_bit(1'b0, 1);
    chk("brk_busy", 32'(b0), 1);
    chk("brk_valid", 32'(v0), 0);
    send_bit(1'b1, 1);
    chk("brk_exit", 32'(b0), 0);
    repeat (6) send_bit(1'b1, 1);
    chk("brk_pulses", 32'(ferr_cnt - fc), 1);
    chk("brk_no_frame", 32'(v0), 0);
    chk("brk_idle", 32'(b0), 0);

    // Reset mid-frame discards the partial word and clears the buffer.
    ready = 1'b0;
    send_bit(1'b0, 1); send_bit(1'b1, 1); send_bit(1'b0, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_busy", 32'(b0), 0);
    chk("mid_rst_dpar", 32'(d0), 0);
    chk("mid_rst_valid", 32'(v0), 0);
    send_data(4'b0110, 1, 1'b0); push_exp(4'b0110); send_bit(1'b1, 1);
    chk("post_rst_word", 32'(d0), 32'(4'b0110));
    ready = 1'b1; step(); step();

`ifdef SERIAL_WORD_RX_PARITY_EN
    send_data(4'b0111, 1, 1'b0); push_exp(4'b0111); send_bit(1'b1, 1);
    step();
    chk("par_good", 32'(pe0), 0);
    send_data(4'b0111, 1, 1'b1); push_exp(4'b0111); send_bit(1'b1, 1);
    chk("par_bad_word", 32'(d0), 32'(4'b0111));
    step();
    chk("par_bad", 32'(pe0), 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("par_cleared", 32'(pe0), 0);
`endif

    repeat (3) step();
    chk("sb_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
